// File: rtl/mem_io_arbiter.sv
// Two-master round-robin arbiter and access sequencer for the shared
// data-memory / memory-mapped-IO path. One access is in flight at a time:
// IDLE picks and latches a request, ACCESS drives one strobe for W+1 cycles,
// and DONE returns a single-cycle ack to the owning master.
module mem_io_arbiter #(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned IO_WAIT  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_mem_read,
    output logic        bus_mem_write,
    output logic        bus_io_read,
    output logic        bus_io_write,
    input  logic [31:0] bus_rdata,
    output logic        busy,
    output logic        grant
);
    localparam logic [3:0] MEM_W = 4'(MEM_WAIT);
    localparam logic [3:0] IO_W  = 4'(IO_WAIT);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        is_io;
    logic        wr;
    logic        last_grant;

    // Candidate access as seen in IDLE
    logic        pick;
    logic        any_req;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_we;
    logic        sel_io;

    // Round-robin pick: a lone requester always wins, a tie goes to the
    // master that did not own the previous access.
    always_comb begin
        any_req   = m0_req | m1_req;
        pick      = (m0_req && m1_req) ? ~last_grant : m1_req;
        sel_addr  = pick ? m1_addr  : m0_addr;
        sel_wdata = pick ? m1_wdata : m0_wdata;
        sel_we    = pick ? m1_we    : m0_we;
        sel_io    = (sel_addr[31:10] == 22'h3FFFFF);
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: ACCESS lasts until the wait counter reaches zero
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Access latch, wait counter, read-data capture and round-robin history
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= 4'd0;
            is_io      <= 1'b0;
            wr         <= 1'b0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            bus_addr   <= 32'd0;
            bus_wdata  <= 32'd0;
            m0_rdata   <= 32'd0;
            m1_rdata   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant     <= pick;
                        bus_addr  <= sel_addr;
                        bus_wdata <= sel_wdata;
                        wr        <= sel_we;
                        is_io     <= sel_io;
                        cnt       <= sel_io ? IO_W : MEM_W;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        // Last strobe cycle: the select stage has the data now
                        if (!wr) begin
                            if (grant) m1_rdata <= bus_rdata;
                            else       m0_rdata <= bus_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE:    last_grant <= grant;
                default: ;
            endcase
        end
    end

    // Strobes and acks decode only registered state, so no path from req
    assign bus_mem_read  = (state == ACCESS) && !is_io && !wr;
    assign bus_mem_write = (state == ACCESS) && !is_io &&  wr;
    assign bus_io_read   = (state == ACCESS) &&  is_io && !wr;
    assign bus_io_write  = (state == ACCESS) &&  is_io &&  wr;
    assign m0_ack        = (state == DONE) && !grant;
    assign m1_ack        = (state == DONE) &&  grant;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mem_io_arbiter.sv
// Self-checking bench for mem_io_arbiter. A reference model derives the
// expected strobe window, ack cycle and returned data from the address map,
// wait parameters and round-robin rule; the memory/IO stage is modelled as
// bus_rdata = bus_addr ^ key.
module tb_mem_io_arbiter;
    localparam int MW = 1;
    localparam int IW = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic [31:0] m0_rdata;
    logic        m0_ack;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [31:0] m1_rdata;
    logic        m1_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_mem_read, bus_mem_write, bus_io_read, bus_io_write;
    logic        busy, grant;

    logic [31:0] key = 32'h0;
    logic [31:0] exp_rd [2];
    int          checks = 0;
    int          failures = 0;

    mem_io_arbiter #(.MEM_WAIT(MW), .IO_WAIT(IW)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_mem_read(bus_mem_read), .bus_mem_write(bus_mem_write),
        .bus_io_read(bus_io_read), .bus_io_write(bus_io_write),
        .bus_rdata(bus_rdata), .busy(busy), .grant(grant)
    );

    assign bus_rdata = bus_addr ^ key;

    always #5 clock = ~clock;

    function automatic bit addr_is_io(logic [31:0] a);
        return a >= 32'hFFFFFC00;
    endfunction

    function automatic int wait_of(logic [31:0] a);
        return addr_is_io(a) ? IW : MW;
    endfunction

    task automatic set_req(int m, bit r, bit w, logic [31:0] a, logic [31:0] d);
        if (m == 0) begin m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d; end
        else        begin m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d; end
    endtask

    // One access from a single requester, starting at posedge+1 with the
    // arbiter idle. Cycle n=1 is the IDLE sample cycle, strobes are
    // expected for n=2..W+2 and the ack at n=W+3.
    task automatic run_single(int m, bit w, logic [31:0] a, logic [31:0] d, bit hold);
        int         wt;
        bit         io;
        logic [3:0] exp_stb, got_stb;
        logic [1:0] exp_ack, got_ack;
        wt = wait_of(a);
        io = addr_is_io(a);
        set_req(m, 1'b1, w, a, d);
        for (int n = 1; n <= wt + 3; n++) begin
            @(negedge clock);
            got_stb = {bus_mem_read, bus_mem_write, bus_io_read, bus_io_write};
            exp_stb = 4'b0000;
            if (n >= 2 && n <= wt + 2)
                exp_stb = io ? (w ? 4'b0001 : 4'b0010) : (w ? 4'b0100 : 4'b1000);
            got_ack = {m1_ack, m0_ack};
            exp_ack = (n == wt + 3) ? (2'b01 << m) : 2'b00;
            checks++;
            if (got_stb !== exp_stb) begin
                failures++;
                $display("FAIL strobes m%0d addr=%h cyc=%0d got=%b exp=%b", m, a, n, got_stb, exp_stb);
            end
            checks++;
            if (got_ack !== exp_ack) begin
                failures++;
                $display("FAIL ack m%0d addr=%h cyc=%0d got=%b exp=%b", m, a, n, got_ack, exp_ack);
            end
            if (n >= 2) begin
                checks++;
                if ({busy, grant, bus_addr, bus_wdata} !== {1'b1, m[0], a, d}) begin
                    failures++;
                    $display("FAIL bus m%0d cyc=%0d got busy=%b grant=%b addr=%h wdata=%h exp 1 %0d %h %h",
                             m, n, busy, grant, bus_addr, bus_wdata, m, a, d);
                end
            end
        end
        if (!w) exp_rd[m] = a ^ key;
        checks++;
        if ({m1_rdata, m0_rdata} !== {exp_rd[1], exp_rd[0]}) begin
            failures++;
            $display("FAIL rdata after m%0d %s got m0=%h m1=%h exp m0=%h m1=%h",
                     m, w ? "write" : "read", m0_rdata, m1_rdata, exp_rd[0], exp_rd[1]);
        end
        @(posedge clock); #1;
        if (!hold) set_req(m, 1'b0, w, a, d);
    endtask

    // Reset with both masters requesting: everything quiet and cleared
    task automatic test_reset();
        key = $urandom;
        set_req(0, 1'b1, 1'b0, 32'h0000_0100, 32'h1111_1111);
        set_req(1, 1'b1, 1'b0, 32'hFFFF_FC04, 32'h2222_2222);
        exp_rd[0] = 32'd0;
        exp_rd[1] = 32'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checks++;
            if ({bus_mem_read, bus_mem_write, bus_io_read, bus_io_write, m0_ack, m1_ack,
                 busy, grant, m0_rdata, m1_rdata} !== 72'd0) begin
                failures++;
                $display("FAIL reset_state i=%0d stb=%b%b%b%b ack=%b%b busy=%b grant=%b r0=%h r1=%h",
                         i, bus_mem_read, bus_mem_write, bus_io_read, bus_io_write,
                         m0_ack, m1_ack, busy, grant, m0_rdata, m1_rdata);
            end
            if (i == 0) begin
                @(posedge clock); #1;
                reset = 1'b0;
            end
        end
    endtask

    // Both masters keep requesting: four acks alternating m0,m1,m0,m1
    // spaced by exactly W+3 cycles of the following access.
    task automatic test_back_to_back();
        int ack_n [4];
        int ack_m [4];
        int exp_n [4];
        int exp_m [4];
        int cnt;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin ack_n[k] = -1; ack_m[k] = -1; end
        exp_m[0] = 0; exp_m[1] = 1; exp_m[2] = 0; exp_m[3] = 1;
        // The IDLE sample cycle was already consumed by the reset check
        exp_n[0] = wait_of(m0_addr) + 2;
        exp_n[1] = exp_n[0] + wait_of(m1_addr) + 3;
        exp_n[2] = exp_n[1] + wait_of(m0_addr) + 3;
        exp_n[3] = exp_n[2] + wait_of(m1_addr) + 3;
        for (int n = 1; n <= 60 && cnt < 4; n++) begin
            @(negedge clock);
            if (m0_ack || m1_ack) begin
                ack_n[cnt] = n;
                ack_m[cnt] = (m0_ack && m1_ack) ? 2 : (m1_ack ? 1 : 0);
                if (m0_ack) exp_rd[0] = m0_addr ^ key;
                if (m1_ack) exp_rd[1] = m1_addr ^ key;
                checks++;
                if ({m1_rdata, m0_rdata} !== {exp_rd[1], exp_rd[0]}) begin
                    failures++;
                    $display("FAIL b2b_rdata ack%0d got m0=%h m1=%h exp m0=%h m1=%h",
                             cnt, m0_rdata, m1_rdata, exp_rd[0], exp_rd[1]);
                end
                cnt++;
            end
        end
        @(posedge clock); #1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ack_m[k] != exp_m[k] || ack_n[k] != exp_n[k]) begin
                failures++;
                $display("FAIL b2b_order ack%0d got master=%0d cyc=%0d exp master=%0d cyc=%0d",
                         k, ack_m[k], ack_n[k], exp_m[k], exp_n[k]);
            end
        end
    endtask

    task automatic test_mem_read();
        key = 32'h1234_5678 ^ 32'h0000_0010;
        run_single(0, 1'b0, 32'h0000_0010, $urandom, 1'b0);
        checks++;
        if (m0_rdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL mem_read_data got=%h exp=12345678", m0_rdata);
        end
    endtask

    task automatic test_io_write();
        key = $urandom;
        run_single(1, 1'b1, 32'hFFFF_FC60, 32'h0000_00FF, 1'b0);
    endtask

    // Reset lands in the second ACCESS cycle of an IO read
    task automatic test_reset_mid_access();
        key = $urandom;
        set_req(0, 1'b1, 1'b0, 32'hFFFF_FC10, 32'h0);
        for (int n = 1; n <= 3; n++) @(negedge clock);
        checks++;
        if (bus_io_read !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_setup io_read got=%b exp=1", bus_io_read);
        end
        reset = 1'b1;
        @(negedge clock);
        set_req(0, 1'b0, 1'b0, 32'hFFFF_FC10, 32'h0);
        exp_rd[0] = 32'd0;
        exp_rd[1] = 32'd0;
        checks++;
        if ({bus_mem_read, bus_mem_write, bus_io_read, bus_io_write, m0_ack, m1_ack,
             busy, grant, bus_addr, m0_rdata, m1_rdata} !== 104'd0) begin
            failures++;
            $display("FAIL mid_reset_state stb=%b%b%b%b ack=%b%b busy=%b grant=%b addr=%h r0=%h r1=%h",
                     bus_mem_read, bus_mem_write, bus_io_read, bus_io_write,
                     m0_ack, m1_ack, busy, grant, bus_addr, m0_rdata, m1_rdata);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clock);
            checks++;
            if ({m0_ack, m1_ack, busy} !== 3'b000) begin
                failures++;
                $display("FAIL mid_reset_quiet cyc=%0d ack=%b%b busy=%b exp 000", n, m0_ack, m1_ack, busy);
            end
        end
        @(posedge clock); #1;
        run_single(1, 1'b0, 32'h0000_0400, $urandom, 1'b0);
    endtask

    // m0 holds req across the write ack and follows with an IO read
    task automatic test_write_then_read();
        key = $urandom;
        run_single(0, 1'b1, 32'h0000_0020, $urandom, 1'b1);
        run_single(0, 1'b0, 32'hFFFF_FC70, $urandom, 1'b0);
    endtask

    task automatic test_random();
        int          m;
        bit          w;
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            key = $urandom;
            m = int'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[31:10] = 22'h3FFFFF;
            else if (a[31:10] == 22'h3FFFFF) a[31] = 1'b0;
            run_single(m, w, a, $urandom, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mem_read();
        test_io_write();
        test_reset_mid_access();
        test_write_then_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
